pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register that replaces the hand-written inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block. It carries a data payload and a control payload between two pipeline stages using a valid/ready handshake, supports stall (backpressure), flush (control bubble injection) and counts bubble cycles for performance analysis. It sits between any two adjacent stages of the 64-bit core pipeline.

## Interface
Parameters:
- DATA_W, 64, width of the data payload (operands, immediate, PC, register indices packed by the instantiating stage)
- CTRL_W, 8, width of the control payload (ALUSrc, ALUOp, Branch, MemRead, MemWrite, RegWrite, MemtoReg, ...)
- CNT_W, 16, width of the bubble counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  upstream stage presents a payload
- in_ready  output  1  this stage accepts the payload this cycle
- in_data  input  DATA_W  upstream data payload
- in_ctrl  input  CTRL_W  upstream control payload
- out_valid  output  1  payload available to downstream
- out_ready  input  1  downstream accepts the payload this cycle
- out_data  output  DATA_W  registered data payload
- out_ctrl  output  CTRL_W  registered control payload; all-zero whenever out_valid is 0
- flush  input  1  discard every held and incoming payload this cycle
- bubble_cnt  output  CNT_W  saturating count of bubble cycles

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Payload data and ctrl always travel together; a payload is never duplicated or reordered.
- out_ctrl is forced to 0 whenever out_valid is 0, so a bubble is a control-level NOP regardless of out_data.
- Flush (priority just below reset): all held entries invalidated, out_valid -> 0, out_ctrl -> 0, incoming payload in the same cycle discarded even if in_valid && in_ready; out_data keeps its old value.
- bubble_cnt increments by 1 in each cycle with out_ready == 1 and out_valid == 0; saturates at 2^CNT_W-1; not cleared by flush.
- Reset (reset == 0 at a rising edge): out_valid = 0, out_ctrl = 0, out_data = 0, bubble_cnt = 0, all entries empty, in_ready = 1 after the edge; inputs ignored while reset is low.

## Timing
- Latency: 1 cycle from transfer in to out_valid high (EMPTY stage).
- Throughput: 1 payload per cycle when out_ready is held high.
- Skid-buffer state machine (PIPE_SKID_EN defined), states by occupancy:
  - EMPTY: in_ready=1, out_valid=0. Transfer in -> ONE.
  - ONE: in_ready=1, out_valid=1. In only -> TWO; out only -> EMPTY; in and out -> ONE with new payload.
  - TWO: in_ready=0, out_valid=1, second payload in skid entry. Transfer out -> ONE, skid entry moves to output.
  - Any state + flush -> EMPTY.
- in_ready is a register output in skid mode (no combinational path from out_ready).
- Simultaneous in and out in ONE: output updates to the incoming payload in the same edge; no bubble.

## Configuration
- PIPE_SKID_EN defined: 2-entry skid buffer per the state machine above; in_ready registered.
- PIPE_SKID_EN undefined: single entry; in_ready = !out_valid || out_ready (combinational); states EMPTY/ONE only; all other behaviour (flush, ctrl zeroing, counter, reset) identical.

## Structure
- Shared package pipe_pkg: state enum (EMPTY, ONE, TWO), default widths, CTRL_NOP constant (all-zero).
- One sub-module is natural: pipe_bubble_ctr (saturating CNT_W counter with enable).
- Stage-specific packing of fields into in_data/in_ctrl stays in the instantiating stage.

## Test plan
- Reset: hold reset=0 for 2 cycles with in_valid=1, in_ctrl=8'hFF -> out_valid=0, out_ctrl=0, bubble_cnt=0, in_ready=1 after release.
- Streaming: in_valid=1, out_ready=1, data 1..10 -> out_data 1..10 in order, one per cycle, first one cycle after acceptance, bubble_cnt unchanged.
- Stall (skid on): accept 0xA, 0xB with out_ready=0 -> state TWO, in_ready=0, 0xC held upstream; raise out_ready -> 0xA, 0xB, 0xC out in order, none lost.
- Flush: in TWO, assert flush with in_valid=1, in_data=0xD -> next cycle out_valid=0, out_ctrl=0, 0xD never appears at output.
- Bubble counter: CNT_W=4, out_ready=1, in_valid=0 for 20 cycles -> bubble_cnt saturates at 15.
- Skid off: out_ready=0 with held payload -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle, back-to-back transfer.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register: occupancy states,
// default payload/counter widths and the control-level NOP encoding.
package pipe_pkg;

  localparam int PIPE_DATA_W = 64;
  localparam int PIPE_CTRL_W = 8;
  localparam int PIPE_CNT_W  = 16;

  // A bubble is represented downstream by an all-zero control word.
  localparam logic [PIPE_CTRL_W-1:0] CTRL_NOP = '0;

  // State name equals the number of payloads currently held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_bubble_ctr.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module pipe_bubble_ctr #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush and bubble counting.
// Define PIPE_SKID_EN for a 2-entry skid buffer with registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [CNT_W-1:0]  bubble_cnt,
  output pipe_state_e       dbg_state
);

  // Handshake: a payload moves across a port on a rising edge where its
  // valid and ready are both high; valid never depends on ready.
  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
  logic              xfer_in, xfer_out;

`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_ready_q, in_ready_d;
`endif

  assign out_valid = (state_q != EMPTY);
  assign xfer_in   = in_valid && in_ready;
  assign xfer_out  = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_ctrl_d = out_ctrl_q;
`ifdef PIPE_SKID_EN
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
`endif
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (xfer_in) begin
            out_data_d = in_data;
            out_ctrl_d = in_ctrl;
            state_d    = ONE;
          end
        end
        ONE: begin
          if (xfer_in && xfer_out) begin
            out_data_d = in_data;
            out_ctrl_d = in_ctrl;
`ifdef PIPE_SKID_EN
          end else if (xfer_in) begin
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = TWO;
`endif
          end else if (xfer_out) begin
            state_d = EMPTY;
          end
        end
`ifdef PIPE_SKID_EN
        TWO: begin
          if (xfer_out) begin
            out_data_d = skid_data_q;
            out_ctrl_d = skid_ctrl_q;
            state_d    = ONE;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
`ifdef PIPE_SKID_EN
    in_ready_d = (state_d != TWO);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_ctrl_q <= '0;
`ifdef PIPE_SKID_EN
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_ctrl_q <= out_ctrl_d;
`ifdef PIPE_SKID_EN
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= in_ready_d;
`endif
    end
  end

`ifdef PIPE_SKID_EN
  assign in_ready = in_ready_q;
`else
  assign in_ready = !out_valid || out_ready;
`endif

  assign out_data  = out_data_q;
  assign out_ctrl  = out_valid ? out_ctrl_q : CTRL_W'(CTRL_NOP);
  assign dbg_state = state_q;

  pipe_bubble_ctr #(
    .CNT_W(CNT_W)
  ) u_bubble_ctr (
    .clk  (clk),
    .reset(reset),
    .en   (out_ready && !out_valid),
    .cnt  (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: reset, streaming, stall, flush,
// bubble saturation and a randomized mix against a queue-based model.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int NW = 4;
  localparam int BUB_MAX = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          flush;
  logic [NW-1:0] bubble_cnt;
  pipe_state_e   dbg_state;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .flush     (flush),
    .bubble_cnt(bubble_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  logic [CW+DW-1:0] exp_q[$];
  int  bub_model = 0;
  int  n_vec  = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;

  function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endfunction

  // Model: held payloads are a FIFO; capacity 2 with the skid buffer, else 1.
  always @(negedge clk) begin
    if (mon_en) begin
      logic             mv;
      logic             ir;
      logic [CW+DW-1:0] ent;
      mv = (exp_q.size() > 0);
`ifdef PIPE_SKID_EN
      ir = (exp_q.size() < 2);
`else
      ir = !mv || out_ready;
`endif
      chk("out_valid", DW'(out_valid), DW'(mv));
      chk("in_ready", DW'(in_ready), DW'(ir));
      chk("bubble_cnt", DW'(bubble_cnt), DW'(bub_model));
      if (!out_valid) chk("out_ctrl_nop", DW'(out_ctrl), '0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", out_data, 'x);
        end else begin
          ent = exp_q.pop_front();
          chk("out_data", out_data, ent[DW-1:0]);
          chk("out_ctrl", DW'(out_ctrl), DW'(ent[CW+DW-1:DW]));
        end
      end
      // Advance the model to the state after the coming rising edge.
      if (out_ready && !mv && bub_model < BUB_MAX) bub_model++;
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; leaves at the next posedge+1.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input bit r, input bit f, output bit acc);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = r;
    flush     = f;
    @(negedge clk);
    acc = v && in_ready && !f;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c, input int stall);
    bit acc = 1'b0;
    int k;
    for (k = 0; k < stall && !acc; k++) cycle(1'b1, d, c, 1'b0, 1'b0, acc);
    for (k = 0; k < 100 && !acc; k++) cycle(1'b1, d, c, 1'b1, 1'b0, acc);
    if (!acc) chk("send_timeout", DW'(acc), DW'(1));
  endtask

  task automatic idle(input int n, input bit r);
    bit acc;
    for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, r, 1'b0, acc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit acc;
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h1234;
    in_ctrl   = 8'hFF;
    out_ready = 1'b1;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_out_ctrl", DW'(out_ctrl), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_bubble_cnt", DW'(bubble_cnt), '0);
    chk("rst_in_ready", DW'(in_ready), DW'(1));
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    mon_en   = 1'b1;

    // Streaming 1..10 with downstream always ready.
    for (int i = 1; i <= 10; i++) send(DW'(i), CW'($urandom_range(1, 255)), 0);
    idle(3, 1'b1);

    // Stall: downstream blocks while A, B, C are offered.
    send(64'hA, 8'h11, 3);
    send(64'hB, 8'h22, 3);
    send(64'hC, 8'h33, 3);
    idle(4, 1'b1);

    // Flush with a fully loaded stage and a payload offered the same cycle.
    send(64'hA, 8'h44, 2);
    cycle(1'b1, 64'hB, 8'h55, 1'b0, 1'b0, acc);
    cycle(1'b1, 64'hD, 8'hFF, 1'b0, 1'b1, acc);
    @(negedge clk);
    chk("flush_out_valid", DW'(out_valid), '0);
    chk("flush_out_ctrl", DW'(out_ctrl), '0);
    @(posedge clk);
    #1;
    idle(3, 1'b1);

    // Bubble counter saturation.
    idle(20, 1'b1);
    @(negedge clk);
    chk("bubble_sat", DW'(bubble_cnt), DW'(BUB_MAX));
    @(posedge clk);
    #1;

    // Randomized mix of valid, ready and occasional flush.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, CW'($urandom),
            1'($urandom_range(0, 3) != 0), $urandom_range(0, 24) == 0, acc);
    end
    idle(5, 1'b1);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
